ps2_scan_rx: RTL and testbench
==============================

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with parameters and ports as listed below.
REQ-002 Parameter FILTER_LEN, default 8, SHALL set the consecutive stable samples needed to accept a ps2c/ps2d level change.
REQ-003 Parameter TIMEOUT_CYC, default 50000, SHALL set the idle cycles mid-frame before the frame is abandoned.
REQ-004 Parameter FIFO_DEPTH, default 16, SHALL set the event FIFO entries; it SHALL be a power of 2, ≥2.
REQ-005 Port clock, input, 1: system clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port ps2c, input, 1: asynchronous PS/2 clock line.
REQ-008 Port ps2d, input, 1: asynchronous PS/2 data line.
REQ-009 Port ev_valid, output, 1: FIFO head holds an event.
REQ-010 Port ev_ready, input, 1: consumer accepts the head when ev_valid is high.
REQ-011 Port ev_code, output, 8: scan code of the head event.
REQ-012 Port ev_ext, output, 1: head event was preceded by E0.
REQ-013 Port ev_rel, output, 1: head event was preceded by F0 (key release).
REQ-014 Port clear_err, input, 1: single-cycle pulse clearing the sticky flags.
REQ-015 Port parity_err, output, 1: sticky parity error.
REQ-016 Port frame_err, output, 1: sticky start, stop or timeout error.
REQ-017 Port overflow, output, 1: sticky flag set when an event is dropped because the FIFO is full.

Function
REQ-018 ps2c and ps2d SHALL each pass through a 2-flop synchroniser and then a filter that changes its output only after FILTER_LEN identical consecutive samples.
REQ-019 A bit SHALL be sampled from filtered ps2d in the cycle a falling edge (1->0) of filtered ps2c is detected.
REQ-020 The frame FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-021 In IDLE, a sampled 0 SHALL enter DATA with the bit counter at 0; a sampled 1 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-022 In DATA, 8 bits SHALL be shifted in LSB first, then the FSM SHALL go to PARITY.
REQ-023 In PARITY, the sampled bit SHALL be stored and the FSM SHALL go to STOP.
REQ-024 In STOP, the FSM SHALL return to IDLE and check the frame.
REQ-025 Parity SHALL be odd: the 8 data bits plus the parity bit SHALL contain an odd number of ones, otherwise parity_err is set.
REQ-026 A stop bit of 0 SHALL set frame_err.
REQ-027 Any errored byte SHALL be discarded and SHALL clear the pending E0/F0 prefix flags.
REQ-028 In any state other than IDLE, TIMEOUT_CYC cycles without a falling edge SHALL force IDLE, set frame_err and discard the partial byte.
REQ-029 A valid byte 8'hE0 SHALL set the ext prefix flag, and a valid byte 8'hF0 SHALL set the rel prefix flag; neither SHALL produce an event.
REQ-030 Any other valid byte SHALL produce the event {ext, rel, code}, and both prefix flags SHALL then clear.
REQ-031 An event SHALL be written into the FIFO on the cycle after the stop-bit sample.
REQ-032 ev_valid SHALL assert on the next cycle when the FIFO was empty (2-cycle latency from the stop-bit sample).
REQ-033 A pop SHALL occur when ev_valid and ev_ready are both high; ev_code, ev_ext and ev_rel SHALL hold stable while ev_valid is high and ev_ready is low.
REQ-034 A push into a full FIFO with no pop in the same cycle SHALL drop the event and set overflow.
REQ-035 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-036 A pop from an empty FIFO SHALL be impossible, because ev_valid is low.
REQ-037 The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide with a wrap bit: full when the indices are equal and the wrap bits differ, empty when the pointers are fully equal.
REQ-038 When clear_err and a new error event occur in the same cycle, the corresponding flag SHALL end up set.

Reset
REQ-039 In any cycle with reset high: FSM=IDLE; bit counter, shift register, prefix flags and timeout counter = 0; FIFO empty; ev_valid=0; ev_code=8'h00; ev_ext=0; ev_rel=0; parity_err=0; frame_err=0; overflow=0; synchroniser and filter outputs=1 (idle bus level).
REQ-040 Reset asserted mid-frame SHALL abandon the frame without raising an error, and the first frame after reset SHALL decode normally.

Structure
REQ-041 Package ps2_pkg SHALL hold the FSM state typedef, the event struct {ext, rel, code[7:0]}, and the constants PS2_EXT=8'hE0 and PS2_REL=8'hF0.
REQ-042 Sub-module ps2_glitch_filter (parameter FILTER_LEN, one instance per line, each including its synchroniser) SHALL be used.
REQ-043 The FIFO SHALL be implemented inline.

Verification
REQ-044 Frame 0x1C with odd parity 0 and stop 1, ev_ready=1 -> one event with code=1C, ext=0, rel=0; ev_valid high 2 cycles after the stop sample; no error flags.
REQ-045 Frames F0 then 1C -> a single event with code=1C, rel=1; frames E0, F0, 75 -> a single event with code=75, ext=1, rel=1.
REQ-046 Frame 0x1C with parity 1 -> parity_err=1 and no event; a following 1C -> an event with rel=0 (prefixes cleared); a clear_err pulse -> parity_err=0.
REQ-047 ps2c held high after 4 data bits for TIMEOUT_CYC cycles -> frame_err=1 and FSM=IDLE; the next frame decodes correctly.
REQ-048 ev_ready=0 while FIFO_DEPTH+1 events are sent -> FIFO_DEPTH events held and overflow=1; draining returns them in order with no loss and no duplicates; a push and pop in the same cycle when full is accepted.
REQ-049 ps2c glitches of FILTER_LEN-1 cycles -> no bit sampled; reset pulsed mid-frame -> no event and no error flags.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Decoded key-event stream: valid/ready handshake carrying {ext, rel, code}.
interface ps2_scan_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_rel;

  modport master (output ev_valid, output ev_code, output ev_ext, output ev_rel,
                  input  ev_ready);
  modport slave  (input  ev_valid, input  ev_code, input  ev_ext, input  ev_rel,
                  output ev_ready);
endinterface

// File: rtl/ps2_glitch_filter.sv
// Two-flop synchroniser followed by a debounce filter; idles (and resets) to the high bus level.
module ps2_glitch_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic line_i,
  output logic line_o
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic            sync1_q, sync2_q, out_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      out_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      // Output flips on the FILTER_LEN-th consecutive sample that differs from it.
      if (sync2_q == out_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        out_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign line_o = out_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frame decode, E0/F0 prefix folding and an event FIFO.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2c,
  input  logic              ps2d,
  ps2_scan_rx_if.master     ev,
  input  logic              clear_err,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overflow
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  logic ps2c_f, ps2d_f, ps2c_prev_q, fall;

  ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clock  (clock),
    .reset  (reset),
    .line_i (ps2c),
    .line_o (ps2c_f)
  );

  ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clock  (clock),
    .reset  (reset),
    .line_i (ps2d),
    .line_o (ps2d_f)
  );

  assign fall = ps2c_prev_q & ~ps2c_f;

  ps2_state_e      state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            parity_q, ext_q, rel_q;
  logic [TmoW-1:0] tmo_q;
  logic            push_q;
  ps2_event_t      push_ev_q;
  logic            parity_err_q, frame_err_q, overflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ps2c_prev_q  <= 1'b1;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      tmo_q        <= '0;
      push_q       <= 1'b0;
      push_ev_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      ps2c_prev_q <= ps2c_f;
      push_q      <= 1'b0;
      // Clears come first so an error raised in the same cycle wins.
      if (clear_err) begin
        parity_err_q <= 1'b0;
        frame_err_q  <= 1'b0;
      end
      if (state_q != StIdle && !fall) begin
        if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          state_q     <= StIdle;
          tmo_q       <= '0;
          frame_err_q <= 1'b1;
          ext_q       <= 1'b0;
          rel_q       <= 1'b0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
      if (fall) begin
        unique case (state_q)
          StIdle: begin
            if (!ps2d_f) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
              shift_q   <= '0;
            end
          end
          StData: begin
            shift_q   <= {ps2d_f, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            parity_q <= ps2d_f;
            state_q  <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (!odd_parity_ok(shift_q, parity_q) || !ps2d_f) begin
              if (!odd_parity_ok(shift_q, parity_q)) parity_err_q <= 1'b1;
              if (!ps2d_f) frame_err_q <= 1'b1;
              ext_q <= 1'b0;
              rel_q <= 1'b0;
            end else if (shift_q == PS2_EXT) begin
              ext_q <= 1'b1;
            end else if (shift_q == PS2_REL) begin
              rel_q <= 1'b1;
            end else begin
              push_q    <= 1'b1;
              push_ev_q <= {ext_q, rel_q, shift_q};
              ext_q     <= 1'b0;
              rel_q     <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Event FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [AW:0] wptr_q, rptr_q;
  ps2_event_t  mem_q [FIFO_DEPTH];
  ps2_event_t  head;
  logic        empty, full, pop, wr_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop   = !empty && ev.ev_ready;
  assign wr_en = push_q && (!full || pop);
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (clear_err) overflow_q <= 1'b0;
      if (push_q && !wr_en) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= push_ev_q;
  end

  assign ev.ev_valid = !empty;
  assign ev.ev_code  = empty ? 8'h00 : head.code;
  assign ev.ev_ext   = !empty && head.ext;
  assign ev.ev_rel   = !empty && head.rel;

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: a stimulus process queues expected events, a monitor checks them.
module tb_ps2_scan_rx;
  import ps2_pkg::*;

  localparam int unsigned FILTER_LEN  = 4;
  localparam int unsigned TIMEOUT_CYC = 400;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int          HALF        = 20;

  logic clock, reset, ps2c, ps2d, clear_err;
  logic parity_err, frame_err, overflow;
  int   chk_cnt = 0;
  int   err_cnt = 0;

  ps2_scan_rx_if ev_if ();
  ps2_event_t    exp_q[$];

  ps2_scan_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .ev         (ev_if.master),
    .clear_err  (clear_err),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: pops on each handshake and checks the head holds while stalled.
  logic       hold;
  logic [9:0] hold_ev;
  initial hold = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (hold && ev_if.ev_valid)
        check("hold_stable", 32'({ev_if.ev_ext, ev_if.ev_rel, ev_if.ev_code}), 32'(hold_ev));
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'({ev_if.ev_ext, ev_if.ev_rel, ev_if.ev_code}), 32'h3ff);
        end else begin
          check("event", 32'({ev_if.ev_ext, ev_if.ev_rel, ev_if.ev_code}),
                32'(exp_q.pop_front()));
        end
      end
      hold    = ev_if.ev_valid && !ev_if.ev_ready;
      hold_ev = {ev_if.ev_ext, ev_if.ev_rel, ev_if.ev_code};
    end else begin
      hold = 1'b0;
    end
  end

  // mode 0: plain, 1: check 2-cycle valid latency, 2: one-cycle ready pulse aligned to the push.
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit stop,
                            input int mode);
    logic [10:0] bits;
    logic        par;
    par  = (~^code) ^ bad_par;
    bits = {stop, par, code, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2d = bits[i];
      tick(HALF);
      ps2c = 1'b0;
      if (i == 10 && mode == 1) begin
        tick(2 + FILTER_LEN + 1);
        check("latency_lo", 32'(ev_if.ev_valid), 32'd0);
        tick(1);
        check("latency_hi", 32'(ev_if.ev_valid), 32'd1);
        tick(HALF - 8);
      end else if (i == 10 && mode == 2) begin
        tick(2 + FILTER_LEN + 1);
        ev_if.ev_ready = 1'b1;
        tick(1);
        ev_if.ev_ready = 1'b0;
        tick(HALF - 8);
      end else begin
        tick(HALF);
      end
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    tick(HALF);
  endtask

  task automatic send_partial(input logic [7:0] code, input int nbits);
    logic [8:0] bits;
    bits = {code, 1'b0};
    for (int i = 0; i <= nbits; i++) begin
      ps2d = bits[i];
      tick(HALF);
      ps2c = 1'b0;
      tick(HALF);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    tick(HALF);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; clear_err = 1'b0; ev_if.ev_ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_code", 32'(ev_if.ev_code), 32'h00);
    check("rst_ext_rel", 32'({ev_if.ev_ext, ev_if.ev_rel}), 32'd0);
    check("rst_flags", 32'({parity_err, frame_err, overflow}), 32'd0);
    reset = 1'b0;
    tick(5);

    // Plain make code with latency check.
    ev_if.ev_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    check("clean_flags", 32'({parity_err, frame_err, overflow}), 32'd0);

    // Prefix folding.
    exp_q.push_back({1'b0, 1'b1, 8'h1C});
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    exp_q.push_back({1'b1, 1'b1, 8'h75});
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    send_frame(8'h75, 1'b0, 1'b1, 0);

    // Parity error discards the byte and the pending prefix.
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    check("parity_err_set", 32'(parity_err), 32'd1);
    check("parity_no_frame_err", 32'(frame_err), 32'd0);
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    pulse_clear();
    check("parity_err_clr", 32'(parity_err), 32'd0);

    // Bad stop bit.
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    check("stop_frame_err", 32'(frame_err), 32'd1);
    pulse_clear();
    check("stop_frame_clr", 32'(frame_err), 32'd0);

    // Mid-frame timeout.
    send_partial(8'h1C, 4);
    check("tmo_not_yet", 32'(frame_err), 32'd0);
    tick(TIMEOUT_CYC);
    check("tmo_frame_err", 32'(frame_err), 32'd1);
    check("tmo_fsm_idle", 32'(dut.state_q), 32'(StIdle));
    exp_q.push_back({1'b0, 1'b0, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    pulse_clear();

    // Short ps2c glitches with data low must not start a frame.
    ps2d = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ps2c = 1'b0;
      tick(FILTER_LEN - 1);
      ps2c = 1'b1;
      tick(10);
    end
    check("glitch_fsm_idle", 32'(dut.state_q), 32'(StIdle));
    ps2d = 1'b1;
    tick(HALF);
    exp_q.push_back({1'b0, 1'b0, 8'h29});
    send_frame(8'h29, 1'b0, 1'b1, 0);

    // Reset mid-frame.
    send_partial(8'h75, 3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);
    check("midrst_flags", 32'({parity_err, frame_err, overflow}), 32'd0);
    check("midrst_valid", 32'(ev_if.ev_valid), 32'd0);
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    check("midrst_no_err", 32'({parity_err, frame_err}), 32'd0);

    // Overflow: FIFO_DEPTH+1 events with the consumer stalled.
    ev_if.ev_ready = 1'b0;
    for (int k = 1; k <= FIFO_DEPTH + 1; k++) begin
      if (k <= FIFO_DEPTH) exp_q.push_back({1'b0, 1'b0, 8'(k)});
      send_frame(8'(k), 1'b0, 1'b1, 0);
    end
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'(ev_if.ev_code), 32'h01);
    pulse_clear();
    check("ovf_clr", 32'(overflow), 32'd0);
    exp_q.push_back({1'b0, 1'b0, 8'h06});
    send_frame(8'h06, 1'b0, 1'b1, 2);
    check("full_push_pop_no_ovf", 32'(overflow), 32'd0);
    check("full_push_pop_head", 32'(ev_if.ev_code), 32'h02);

    // Drain.
    ev_if.ev_ready = 1'b1;
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick(1);
    tick(5);
    check("drain_empty_q", 32'(exp_q.size()), 32'd0);
    check("drain_valid_lo", 32'(ev_if.ev_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
